reg_cmd_ctrl: RTL and testbench
===============================

Name: reg_cmd_ctrl

Overview:
- Command controller directly upstream of the register file.
- Parses byte-stream frames from the UART RX path and drives the register file write/read ports.
- Triggers the ALU, which reads its operands from REG0/REG1, and gates the ALU clock for low power.
- Returns read data and ALU results to the UART TX FIFO as bytes, honouring FIFO backpressure.

Parameters:
- WIDTH, 8: data/byte width; must equal the register file WIDTH.
- ADDR, 4: register file address width.
- ALU_W, 16: ALU result width; must be 2*WIDTH.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  WIDTH  received byte
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RF_WrEn  out  1  register file write enable
- RF_RdEn  out  1  register file read enable
- RF_Address  out  ADDR  register file address
- RF_WrData  out  WIDTH  register file write data
- RF_RdData  in  WIDTH  register file read data
- RF_RdData_VLD  in  1  read data valid; arrives 1 cycle after RF_RdEn
- ALU_EN  out  1  one-cycle ALU start pulse
- ALU_FUN  out  4  ALU function code
- ALU_OUT  in  ALU_W  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- CLK_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  WIDTH  byte to TX FIFO
- TX_D_VLD  out  1  one-cycle FIFO write strobe
- FIFO_FULL  in  1  TX FIFO full

Behaviour:
- Reset is RST, asynchronous, active-low; clock is CLK.
- On reset: all outputs are 0, the FSM is in IDLE, and all capture registers are cleared.
- All outputs are registered. A strobe caused by a byte is asserted in the cycle after that byte's RX_D_VLD and lasts exactly one cycle.
- Opcodes:
  - 0xAA: write, frame = addr, data
  - 0xBB: read, frame = addr
  - 0xCC: ALU with operands, frame = A, B, fun
  - 0xDD: ALU without operands, frame = fun
- IDLE:
  - RX_D_VLD with a valid opcode moves to WR_ADDR, RD_ADDR, OP_A or FUN respectively.
  - Any other byte is discarded; the FSM stays in IDLE.
- WR_ADDR: on a byte, latch RX_P_DATA[ADDR-1:0] (upper bits ignored), then go to WR_DATA.
- WR_DATA: on a byte, pulse RF_WrEn with the latched address and the byte as RF_WrData, then go to IDLE.
- RD_ADDR: on a byte, latch the address and pulse RF_RdEn, then go to RD_WAIT.
- RD_WAIT: on RF_RdData_VLD, capture RF_RdData, then go to TX_LO with a 1-byte count.
- OP_A: on a byte, pulse RF_WrEn to address 0, then go to OP_B.
- OP_B: on a byte, pulse RF_WrEn to address 1, then go to FUN.
- FUN:
  - CLK_EN is high from entry.
  - On a byte: ALU_FUN <= byte[3:0] and pulse ALU_EN, then go to ALU_WAIT.
  - ALU_FUN holds its value until the next function byte.
- ALU_WAIT: CLK_EN stays high. On ALU_OUT_VLD, capture ALU_OUT, then go to TX_LO with a 2-byte count.
- CLK_EN is low in every state other than FUN and ALU_WAIT.
- TX_LO:
  - If FIFO_FULL is high, hold with no strobe.
  - Otherwise pulse TX_D_VLD with the captured low byte.
  - Then go to TX_HI if the count is 2, else to IDLE.
- TX_HI: same FIFO_FULL rule as TX_LO, but sends the high byte, then goes to IDLE.
- Ignored inputs:
  - RX_D_VLD in RD_WAIT, ALU_WAIT, TX_LO and TX_HI is dropped.
  - RF_RdData_VLD and ALU_OUT_VLD are ignored outside their wait states.
- RF_WrEn and RF_RdEn are never high in the same cycle.
- RF_Address and RF_WrData hold their values between strobes.
- Reset mid-frame: FSM returns to IDLE, strobes drop immediately, and the partial frame is lost.
- There are no timeouts. A missing valid holds the wait state until reset.

Decomposition:
- Shared package holds:
  - opcode constants CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD
  - the FSM state encoding
  - the operand addresses OPA_ADDR=0 and OPB_ADDR=1
- One sub-module, reg_cmd_tx: a 1/2-byte serializer with FIFO_FULL backpressure, owning the TX_LO and TX_HI behaviour.

Test Plan:
- Write: bytes AA,05,3C → RF_WrEn single pulse with RF_Address=5 and RF_WrData=0x3C, one cycle after the 3C byte; FSM back in IDLE.
- Read: BB,05 with RF_RdData=0x3C returned one cycle after RF_RdEn → exactly one TX_D_VLD with TX_P_DATA=0x3C.
- ALU with operands: CC,0A,03,00 and ALU_OUT=0x000D →
  - writes 0A to address 0 and 03 to address 1;
  - ALU_FUN=0 with a single ALU_EN pulse;
  - CLK_EN high only from FUN through ALU_OUT_VLD;
  - TX bytes 0D then 00.
- Backpressure: DD,02 with ALU_OUT=0x1234 and FIFO_FULL held high for 5 cycles → no strobe while full; then 34 and 12 are sent on consecutive non-full cycles.
- Robustness:
  - byte 0x55 in IDLE → no outputs;
  - RST asserted after AA,07 → all outputs 0;
  - next frame BB,07 proceeds normally.

Source files
------------

// File: rtl/reg_cmd_ctrl_pkg.sv
// reg_cmd_ctrl_pkg: opcodes, operand addresses and state encodings shared by the command controller.
package reg_cmd_ctrl_pkg;
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;
  typedef enum logic [3:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, FUN, ALU_WAIT, TX} state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LO, TX_HI} tx_state_t;
endpackage

// File: rtl/reg_cmd_tx.sv
// reg_cmd_tx: captures a 1- or 2-byte response and writes it low byte first into the TX FIFO, stalling while full.
module reg_cmd_tx
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALU_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic             two_i,
  input  logic [ALU_W-1:0] data_i,
  input  logic             full_i,
  output logic [WIDTH-1:0] tx_data_o,
  output logic             tx_vld_o,
  output logic             done_o
);
  tx_state_t st_q, st_d;
  logic [ALU_W-1:0] data_q;
  logic [WIDTH-1:0] byte_q;
  logic two_q, vld_q, send;
  assign send = st_q != TX_IDLE && !full_i;
  assign done_o = send && (st_q == TX_HI || !two_q);
  always_comb
    st_d = st_q == TX_IDLE ? (load_i ? TX_LO : TX_IDLE) :
           !send ? st_q :
           (st_q == TX_LO && two_q) ? TX_HI : TX_IDLE;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      st_q   <= TX_IDLE;
      data_q <= '0;
      byte_q <= '0;
      two_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      vld_q <= send;
      if (send) byte_q <= st_q == TX_HI ? data_q[ALU_W-1 -: WIDTH] : data_q[WIDTH-1:0];
      if (load_i) begin
        data_q <= data_i;
        two_q  <= two_i;
      end
    end
  assign tx_data_o = byte_q;
  assign tx_vld_o  = vld_q;
endmodule

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: parses UART command frames into register-file writes/reads and ALU runs, returning results as bytes.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4,
  parameter int ALU_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic             RF_WrEn,
  output logic             RF_RdEn,
  output logic [ADDR-1:0]  RF_Address,
  output logic [WIDTH-1:0] RF_WrData,
  input  logic [WIDTH-1:0] RF_RdData,
  input  logic             RF_RdData_VLD,
  output logic             ALU_EN,
  output logic [3:0]       ALU_FUN,
  input  logic [ALU_W-1:0] ALU_OUT,
  input  logic             ALU_OUT_VLD,
  output logic             CLK_EN,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             FIFO_FULL
);
  state_t st_q, st_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d, clk_en_q, clk_en_d;
  logic [ADDR-1:0] addr_q, addr_d, lat_q, lat_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0] fun_q, fun_d;
  logic load, two, done;
  logic [ALU_W-1:0] cap;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      st_q     <= IDLE;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      alu_en_q <= 1'b0;
      clk_en_q <= 1'b0;
      addr_q   <= '0;
      lat_q    <= '0;
      wdata_q  <= '0;
      fun_q    <= '0;
    end else begin
      st_q     <= st_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      alu_en_q <= alu_en_d;
      clk_en_q <= clk_en_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      wdata_q  <= wdata_d;
      fun_q    <= fun_d;
    end
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:     if (RX_D_VLD) st_d = RX_P_DATA == CMD_WR      ? WR_ADDR :
                                     RX_P_DATA == CMD_RD      ? RD_ADDR :
                                     RX_P_DATA == CMD_ALU_OP  ? OP_A    :
                                     RX_P_DATA == CMD_ALU_NOP ? FUN     : IDLE;
      WR_ADDR:  if (RX_D_VLD) st_d = WR_DATA;
      WR_DATA:  if (RX_D_VLD) st_d = IDLE;
      RD_ADDR:  if (RX_D_VLD) st_d = RD_WAIT;
      RD_WAIT:  if (RF_RdData_VLD) st_d = TX;
      OP_A:     if (RX_D_VLD) st_d = OP_B;
      OP_B:     if (RX_D_VLD) st_d = FUN;
      FUN:      if (RX_D_VLD) st_d = ALU_WAIT;
      ALU_WAIT: if (ALU_OUT_VLD) st_d = TX;
      TX:       if (done) st_d = IDLE;
      default:  st_d = IDLE;
    endcase
  end
  // The write address is held in lat_q so RF_Address only changes on a strobe.
  always_comb begin
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    alu_en_d = 1'b0;
    addr_d   = addr_q;
    lat_d    = lat_q;
    wdata_d  = wdata_q;
    fun_d    = fun_q;
    clk_en_d = st_d == FUN || st_d == ALU_WAIT;
    if (RX_D_VLD)
      case (st_q)
        WR_ADDR: lat_d = RX_P_DATA[ADDR-1:0];
        WR_DATA: begin
          wr_en_d = 1'b1;
          addr_d  = lat_q;
          wdata_d = RX_P_DATA;
        end
        RD_ADDR: begin
          rd_en_d = 1'b1;
          addr_d  = RX_P_DATA[ADDR-1:0];
        end
        OP_A, OP_B: begin
          wr_en_d = 1'b1;
          addr_d  = st_q == OP_A ? ADDR'(OPA_ADDR) : ADDR'(OPB_ADDR);
          wdata_d = RX_P_DATA;
        end
        FUN: begin
          alu_en_d = 1'b1;
          fun_d    = RX_P_DATA[3:0];
        end
        default: ;
      endcase
  end
  assign load = (st_q == RD_WAIT && RF_RdData_VLD) || (st_q == ALU_WAIT && ALU_OUT_VLD);
  assign two  = st_q == ALU_WAIT;
  assign cap  = two ? ALU_OUT : ALU_W'(RF_RdData);
  reg_cmd_tx #(.WIDTH(WIDTH), .ALU_W(ALU_W)) u_tx (
    .CLK(CLK), .RST(RST), .load_i(load), .two_i(two), .data_i(cap), .full_i(FIFO_FULL),
    .tx_data_o(TX_P_DATA), .tx_vld_o(TX_D_VLD), .done_o(done)
  );
  assign RF_WrEn    = wr_en_q;
  assign RF_RdEn    = rd_en_q;
  assign RF_Address = addr_q;
  assign RF_WrData  = wdata_q;
  assign ALU_EN     = alu_en_q;
  assign ALU_FUN    = fun_q;
  assign CLK_EN     = clk_en_q;
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: directed frames with a queue of expected strobes checked by an independent monitor.
module tb_reg_cmd_ctrl;
  logic CLK = 1'b0, RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic RX_D_VLD = 1'b0;
  logic RF_WrEn, RF_RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [3:0] RF_Address, ALU_FUN;
  logic [7:0] RF_WrData, TX_P_DATA;
  logic [7:0] RF_RdData = '0;
  logic RF_RdData_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic ALU_OUT_VLD = 1'b0;
  logic FIFO_FULL = 1'b0;
  logic [7:0] rd_val = '0;
  logic [15:0] alu_val = '0;
  logic full_at_edge = 1'b0;
  logic [28:0] outs;
  logic [31:0] exp_q[$];
  int n_chk = 0, n_pass = 0;

  reg_cmd_ctrl #(.WIDTH(8), .ADDR(4), .ALU_W(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
  );

  assign outs = {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD};

  initial forever #5 CLK = ~CLK;

  // Event word: kind (0 write, 1 read, 2 alu start, 3 tx byte), address/function, data.
  function automatic logic [31:0] ev(input int k, input int a, input int b);
    return {8'(k), 8'(a), 16'(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic pop(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: unexpected strobe %h, expected none", name, act);
    end else check(name, act, exp_q.pop_front());
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge CLK);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge CLK);
    #1;
  endtask

  // Register file model: read data one cycle after the read enable.
  initial forever begin
    @(posedge CLK);
    full_at_edge = FIFO_FULL;
    #1;
    RF_RdData_VLD = RF_RdEn;
    RF_RdData = rd_val;
  end

  // ALU model: result two cycles after the start pulse.
  initial forever begin
    @(posedge CLK);
    #1;
    ALU_OUT_VLD = 1'b0;
    if (ALU_EN) begin
      repeat (2) @(posedge CLK);
      #1;
      ALU_OUT = alu_val;
      ALU_OUT_VLD = 1'b1;
    end
  end

  // Monitor: every strobe must match the next expected event.
  initial forever begin
    @(negedge CLK);
    if (RST) begin
      if (RF_WrEn || RF_RdEn) check("wr_rd_exclusive", 32'(RF_WrEn & RF_RdEn), 32'd0);
      if (RF_WrEn) pop("rf_write", ev(0, RF_Address, RF_WrData));
      if (RF_RdEn) pop("rf_read", ev(1, RF_Address, 0));
      if (ALU_EN) pop("alu_start", ev(2, ALU_FUN, 0));
      if (TX_D_VLD) begin
        check("tx_not_full", 32'(full_at_edge), 32'd0);
        pop("tx_byte", ev(3, 0, TX_P_DATA));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", 32'(outs), 32'd0);
    RST = 1'b1;
    exp_q.push_back(ev(0, 5, 'h3C));
    send(8'hAA);
    send(8'h05);
    send(8'h3C);
    check("wr_timing", 32'(RF_WrEn), 32'd1);
    drain("write_done");
    check("wr_held", 32'({RF_Address, RF_WrData}), 32'h53C);
    rd_val = 8'h3C;
    exp_q.push_back(ev(1, 5, 0));
    exp_q.push_back(ev(3, 0, 'h3C));
    send(8'hBB);
    send(8'h05);
    check("rd_timing", 32'(RF_RdEn), 32'd1);
    drain("read_done");
    alu_val = 16'h000D;
    exp_q.push_back(ev(0, 0, 'h0A));
    exp_q.push_back(ev(0, 1, 'h03));
    exp_q.push_back(ev(2, 0, 0));
    exp_q.push_back(ev(3, 0, 'h0D));
    exp_q.push_back(ev(3, 0, 'h00));
    send(8'hCC);
    check("clk_en_opcode", 32'(CLK_EN), 32'd0);
    send(8'h0A);
    check("clk_en_opa", 32'(CLK_EN), 32'd0);
    send(8'h03);
    check("clk_en_fun", 32'(CLK_EN), 32'd1);
    send(8'h00);
    check("alu_en_timing", 32'(ALU_EN), 32'd1);
    check("clk_en_wait", 32'(CLK_EN), 32'd1);
    drain("alu_op_done");
    check("clk_en_after", 32'(CLK_EN), 32'd0);
    alu_val = 16'h1234;
    FIFO_FULL = 1'b1;
    exp_q.push_back(ev(2, 2, 0));
    exp_q.push_back(ev(3, 0, 'h34));
    exp_q.push_back(ev(3, 0, 'h12));
    send(8'hDD);
    check("clk_en_nop_fun", 32'(CLK_EN), 32'd1);
    send(8'h02);
    repeat (8) @(posedge CLK);
    #1;
    check("bp_held", 32'(exp_q.size()), 32'd2);
    FIFO_FULL = 1'b0;
    @(negedge CLK);
    check("bp_idle", 32'(TX_D_VLD), 32'd0);
    @(negedge CLK);
    check("bp_lo", 32'({TX_D_VLD, TX_P_DATA}), 32'h134);
    @(negedge CLK);
    check("bp_hi", 32'({TX_D_VLD, TX_P_DATA}), 32'h112);
    @(negedge CLK);
    check("bp_end", 32'(TX_D_VLD), 32'd0);
    drain("bp_done");
    check("alu_fun_held", 32'(ALU_FUN), 32'd2);
    send(8'h55);
    check("junk_no_strobe", 32'({RF_WrEn, RF_RdEn, ALU_EN, CLK_EN, TX_D_VLD}), 32'd0);
    drain("junk_done");
    send(8'hAA);
    send(8'h07);
    RST = 1'b0;
    #1;
    check("reset_mid", 32'(outs), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    rd_val = 8'h5A;
    exp_q.push_back(ev(1, 7, 0));
    exp_q.push_back(ev(3, 0, 'h5A));
    send(8'hBB);
    send(8'h07);
    drain("read_after_reset");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
